spike_tag_fifo: RTL and testbench
=================================

// Module: spike_tag_fifo
// PURPOSE
//  Producer end of the fifo_empty/req_deq/fired_tag/i_tag handshake consumed by compute_in_memory.
//  Neuron update logic enqueues one {fired_tag, i_tag} spike event per fired neuron.
//  compute_in_memory dequeues events with req_deq and accumulates synaptic current.
//  Circular buffer with first-word-fall-through read, occupancy count, sticky overflow/underflow and flush.
// PARAMETERS
//  TAG_W    1  width of fired_tag (presynaptic neuron id)
//  ITAG_W   1  width of i_tag (current-buffer select)
//  DEPTH    8  number of entries; power of two, >= 2
//  ADDR_W   3  log2(DEPTH)
// PORTS
//  clk         in   1        clock, all state on rising edge
//  reset       in   1        synchronous active-high reset
//  flush       in   1        synchronous clear of contents; flags retained
//  enq         in   1        write request, one event per cycle
//  fired_tag_in in  TAG_W    tag to write
//  i_tag_in    in   ITAG_W   current-buffer select to write
//  req_deq     in   1        pop request from compute_in_memory
//  fifo_empty  out  1        no valid entry at head
//  fifo_full   out  1        count == DEPTH
//  fired_tag   out  TAG_W    head entry tag (valid when !fifo_empty)
//  i_tag       out  ITAG_W   head entry i_tag (valid when !fifo_empty)
//  count       out  ADDR_W+1 current occupancy 0..DEPTH
//  overflow    out  1        sticky: enq dropped while full
//  underflow   out  1        sticky: req_deq while empty
// BEHAVIOUR
//  - Reset, synchronous active-high, dominates all inputs: wr_ptr=rd_ptr=0, count=0, fifo_empty=1,
//    fifo_full=0, overflow=0, underflow=0, fired_tag=0, i_tag=0. Storage array not cleared.
//  - Reset asserted mid-operation discards all entries on that edge; first enq after deassert lands at entry 0.
//  - Registered status: fifo_empty, fifo_full, count reflect state after the last edge; no comb paths from inputs.
//  - Read is first-word-fall-through: fired_tag/i_tag driven combinationally from mem[rd_ptr];
//    when fifo_empty=1 outputs forced to 0.
//  - Write latency: enq at edge N -> fifo_empty=0 and data at head after edge N (visible cycle N+1).
//  - Pop: req_deq=1 and !fifo_empty at edge -> rd_ptr+1, count-1; next head visible next cycle.
//  - Consumer holds req_deq for exactly one cycle per event; each edge with req_deq && !empty pops one entry.
//  - Pointers wrap modulo DEPTH (ADDR_W bits, natural wrap); count is ADDR_W+1 bits, never wraps.
//  - enq && !full: write mem[wr_ptr], wr_ptr+1, count+1.
//  - enq && full && !req_deq: write dropped, pointers/count unchanged, overflow<=1.
//  - enq && full && req_deq: pop and push both occur, count stays DEPTH (pass-through allowed).
//  - enq && empty && req_deq: push only, underflow<=1, count becomes 1.
//  - req_deq && empty && !enq: no state change except underflow<=1.
//  - enq && req_deq, 0<count<DEPTH: both occur, count unchanged.
//  - flush (reset=0): pointers=0, count=0, fifo_empty=1, fifo_full=0; enq/req_deq in same cycle ignored;
//    overflow/underflow NOT cleared (only reset clears them).
//  - fifo_full = (count==DEPTH); fifo_empty = (count==0); exactly one of full/empty/partial at any time.
// TESTING
//  1 reset held 2 cycles with enq=1, req_deq=1 -> fifo_empty=1, count=0, overflow=0, underflow=0 after release.
//  2 enq tags 1,0,1 (i_tag 0,1,1) on 3 cycles, then req_deq 3 cycles -> heads read {1,0},{0,1},{1,1}, then fifo_empty=1, count=0.
//  3 enq 8 events (DEPTH=8) -> fifo_full=1, count=8; 9th enq alone -> overflow=1, count=8, head unchanged.
//  4 full + enq & req_deq same cycle -> count stays 8, oldest popped, new entry at tail; 20 push/pop cycles cross pointer wrap with in-order data.
//  5 empty + req_deq -> underflow=1, count=0; empty + enq & req_deq -> count=1, underflow=1, head = new entry.
//  6 count=5, flush=1 with enq=1 -> count=0, fifo_empty=1, overflow/underflow unchanged; next enq appears at head next cycle.

Source files
------------

// File: rtl/spike_tag_fifo_if.sv
// Spike-event queue bundle: producer write side, consumer pop side and queue status.
// The fifo takes the slave view; neuron update logic and the consumer use master.
interface spike_tag_fifo_if #(
  parameter int TAG_W  = 1,
  parameter int ITAG_W = 1,
  parameter int ADDR_W = 3
);
  logic              flush;
  logic              enq;
  logic [TAG_W-1:0]  fired_tag_in;
  logic [ITAG_W-1:0] i_tag_in;
  logic              req_deq;
  logic              fifo_empty;
  logic              fifo_full;
  logic [TAG_W-1:0]  fired_tag;
  logic [ITAG_W-1:0] i_tag;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, enq, fired_tag_in, i_tag_in, req_deq,
    input  fifo_empty, fifo_full, fired_tag, i_tag, count, overflow, underflow
  );

  modport slave (
    input  flush, enq, fired_tag_in, i_tag_in, req_deq,
    output fifo_empty, fifo_full, fired_tag, i_tag, count, overflow, underflow
  );
endinterface

// File: rtl/spike_tag_fifo.sv
// Circular spike-event queue feeding compute_in_memory: first-word-fall-through head,
// registered occupancy/status, sticky overflow/underflow and a content-only flush.
module spike_tag_fifo #(
  parameter int TAG_W  = 1,
  parameter int ITAG_W = 1,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  spike_tag_fifo_if.slave     bus
);
  localparam int              WORD_W  = TAG_W + ITAG_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              empty_r;
  logic              full_r;
  logic              overflow_r;
  logic              underflow_r;

  logic              push_s;
  logic              pop_s;
  logic [ADDR_W:0]   count_nxt_s;
  logic [WORD_W-1:0] head_s;

  // Push/pop qualification; a full queue still accepts a write when the head leaves on the same edge.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (bus.flush) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      pop_s  = bus.req_deq && !empty_r;
      push_s = bus.enq && (!full_r || bus.req_deq);
    end
  end

  // Next occupancy from the qualified push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy, status and sticky error flags; flush keeps the error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == '0);
      full_r  <= (count_nxt_s == DEPTH_C);
      if (bus.enq && full_r && !bus.req_deq) overflow_r  <= 1'b1;
      if (bus.req_deq && empty_r)            underflow_r <= 1'b1;
    end
  end

  // Event storage; contents are never cleared, only the pointers are.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      mem_r[wr_ptr_r] <= {bus.fired_tag_in, bus.i_tag_in};
    end
  end

  // Fall-through head, forced to zero while nothing valid is queued.
  always_comb begin
    head_s = '0;
    if (empty_r) begin
      head_s = '0;
    end else begin
      head_s = mem_r[rd_ptr_r];
    end
  end

  assign bus.fired_tag  = head_s[WORD_W-1:ITAG_W];
  assign bus.i_tag      = head_s[ITAG_W-1:0];
  assign bus.fifo_empty = empty_r;
  assign bus.fifo_full  = full_r;
  assign bus.count      = count_r;
  assign bus.overflow   = overflow_r;
  assign bus.underflow  = underflow_r;
endmodule

// File: tb/tb_spike_tag_fifo.sv
// Directed self-checking bench for spike_tag_fifo (DEPTH=8, 1-bit tags).
module tb_spike_tag_fifo;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  spike_tag_fifo_if #(.TAG_W(1), .ITAG_W(1), .ADDR_W(3)) bus ();

  spike_tag_fifo #(.TAG_W(1), .ITAG_W(1), .DEPTH(8), .ADDR_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Event pattern {fired_tag, i_tag} for sequence index j.
  function automatic logic [1:0] pat(input int j);
    logic [3:0] b;
    b = j[3:0];
    return {b[0] ^ b[2], b[1] ^ b[3] ^ b[0]};
  endfunction

  task automatic enq_one(input logic [1:0] d);
    bus.enq = 1'b1;
    {bus.fired_tag_in, bus.i_tag_in} = d;
    tick();
    bus.enq = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.enq = 1'b1; bus.req_deq = 1'b1; bus.fired_tag_in = 1'b1; bus.i_tag_in = 1'b1;
    tick(); tick();
    reset = 1'b0; bus.enq = 1'b0; bus.req_deq = 1'b0;
    tick();
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", bus.fifo_empty); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", bus.overflow); end
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got=%0b exp=0", bus.underflow); end
    checks++; if (bus.fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", bus.fifo_full); end
    checks++; if ({bus.fired_tag, bus.i_tag} !== 2'b00) begin errors++; $display("FAIL reset_head got=%b exp=00", {bus.fired_tag, bus.i_tag}); end
  endtask

  task automatic test_basic();
    logic [1:0] exp_q [3];
    exp_q[0] = 2'b10; exp_q[1] = 2'b01; exp_q[2] = 2'b11;
    for (int i = 0; i < 3; i++) enq_one(exp_q[i]);
    checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL basic_count got=%0d exp=3", bus.count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if ({bus.fired_tag, bus.i_tag} !== exp_q[i]) begin errors++; $display("FAIL basic_head%0d got=%b exp=%b", i, {bus.fired_tag, bus.i_tag}, exp_q[i]); end
      bus.req_deq = 1'b1;
      tick();
      bus.req_deq = 1'b0;
    end
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL basic_empty got=%0b exp=1", bus.fifo_empty); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL basic_count_end got=%0d exp=0", bus.count); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) enq_one(pat(i));
    checks++; if (bus.fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%0b exp=1", bus.fifo_full); end
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL ovf_count8 got=%0d exp=8", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%0b exp=0", bus.overflow); end
    enq_one(2'b11);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", bus.overflow); end
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL ovf_count got=%0d exp=8", bus.count); end
    checks++; if ({bus.fired_tag, bus.i_tag} !== pat(0)) begin errors++; $display("FAIL ovf_head got=%b exp=%b", {bus.fired_tag, bus.i_tag}, pat(0)); end
  endtask

  task automatic test_pass_through();
    for (int k = 0; k < 20; k++) begin
      checks++; if ({bus.fired_tag, bus.i_tag} !== pat(k)) begin errors++; $display("FAIL pt_head%0d got=%b exp=%b", k, {bus.fired_tag, bus.i_tag}, pat(k)); end
      bus.enq = 1'b1; bus.req_deq = 1'b1;
      {bus.fired_tag_in, bus.i_tag_in} = pat(8 + k);
      tick();
      checks++; if (bus.count !== 4'd8 || bus.fifo_full !== 1'b1) begin errors++; $display("FAIL pt_count%0d got=%0d/%0b exp=8/1", k, bus.count, bus.fifo_full); end
    end
    bus.enq = 1'b0;
    for (int k = 20; k < 28; k++) begin
      checks++; if ({bus.fired_tag, bus.i_tag} !== pat(k)) begin errors++; $display("FAIL drain_head%0d got=%b exp=%b", k, {bus.fired_tag, bus.i_tag}, pat(k)); end
      bus.req_deq = 1'b1;
      tick();
    end
    bus.req_deq = 1'b0;
    checks++; if (bus.fifo_empty !== 1'b1 || bus.count !== 4'd0) begin errors++; $display("FAIL drain_end got=%0b/%0d exp=1/0", bus.fifo_empty, bus.count); end
    checks++; if (bus.underflow !== 1'b0 || bus.overflow !== 1'b1) begin errors++; $display("FAIL drain_flags got=%0b%0b exp=01", bus.underflow, bus.overflow); end
  endtask

  task automatic test_underflow();
    enq_one(2'b01); enq_one(2'b11);
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (bus.count !== 4'd0 || bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL midreset got=%0d/%0b exp=0/1", bus.count, bus.fifo_empty); end
    bus.req_deq = 1'b1; tick(); bus.req_deq = 1'b0;
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL unf_flag got=%0b exp=1", bus.underflow); end
    checks++; if (bus.count !== 4'd0 || bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL unf_count got=%0d/%0b exp=0/1", bus.count, bus.fifo_empty); end
    reset = 1'b1; tick(); reset = 1'b0;
    bus.enq = 1'b1; bus.req_deq = 1'b1; {bus.fired_tag_in, bus.i_tag_in} = 2'b10;
    tick();
    bus.enq = 1'b0; bus.req_deq = 1'b0;
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL unf_push_count got=%0d exp=1", bus.count); end
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL unf_push_flag got=%0b exp=1", bus.underflow); end
    checks++; if ({bus.fired_tag, bus.i_tag} !== 2'b10) begin errors++; $display("FAIL unf_push_head got=%b exp=10", {bus.fired_tag, bus.i_tag}); end
    bus.req_deq = 1'b1; tick(); bus.req_deq = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 8; i++) enq_one(pat(i));
    enq_one(2'b11);
    bus.req_deq = 1'b1; tick(); tick(); tick(); bus.req_deq = 1'b0;
    checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL flush_pre_count got=%0d exp=5", bus.count); end
    checks++; if ({bus.fired_tag, bus.i_tag} !== pat(3)) begin errors++; $display("FAIL flush_pre_head got=%b exp=%b", {bus.fired_tag, bus.i_tag}, pat(3)); end
    bus.flush = 1'b1; bus.enq = 1'b1; {bus.fired_tag_in, bus.i_tag_in} = 2'b11;
    tick();
    bus.flush = 1'b0; bus.enq = 1'b0;
    checks++; if (bus.count !== 4'd0 || bus.fifo_empty !== 1'b1 || bus.fifo_full !== 1'b0) begin errors++; $display("FAIL flush_state got=%0d/%0b/%0b exp=0/1/0", bus.count, bus.fifo_empty, bus.fifo_full); end
    checks++; if (bus.overflow !== 1'b1 || bus.underflow !== 1'b1) begin errors++; $display("FAIL flush_flags got=%0b%0b exp=11", bus.overflow, bus.underflow); end
    checks++; if ({bus.fired_tag, bus.i_tag} !== 2'b00) begin errors++; $display("FAIL flush_head got=%b exp=00", {bus.fired_tag, bus.i_tag}); end
    enq_one(2'b01);
    checks++; if ({bus.fired_tag, bus.i_tag} !== 2'b01 || bus.count !== 4'd1) begin errors++; $display("FAIL flush_next got=%b/%0d exp=01/1", {bus.fired_tag, bus.i_tag}, bus.count); end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1;
    bus.flush = 1'b0; bus.enq = 1'b0; bus.req_deq = 1'b0;
    bus.fired_tag_in = 1'b0; bus.i_tag_in = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_pass_through();
    test_underflow();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
